// File: rtl/pid_pkg.sv
// Shared types and widths for the PID position controller.
// Includes the update-sequence FSM encoding and the datapath word sizes.
package pid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERR,
        ST_MUL_P,
        ST_MUL_I,
        ST_MUL_D,
        ST_SUM,
        ST_SAT
    } pid_state_t;

    localparam int DATA_W = 16;
    localparam int COEF_W = 8;
    localparam int E_W    = 17;
    localparam int D_W    = 18;
    localparam int I_W    = 24;
    localparam int ACC_W  = 40;
    localparam int Q_FRAC = 4;

endpackage

// File: rtl/pid_position_ctrl_if.sv
// Sample/command bundle between the filter, the PID block and the driver.
// The controller sits on the slave side; the sample source and command sink form the master side.
interface pid_position_ctrl_if;
    import pid_pkg::*;

    logic                     meas_valid;
    logic        [DATA_W-1:0] meas_in;
    logic        [DATA_W-1:0] setpoint;
    logic        [COEF_W-1:0] kp;
    logic        [COEF_W-1:0] ki;
    logic        [COEF_W-1:0] kd;
    logic                     clr;
    logic signed [DATA_W-1:0] u_out;
    logic                     u_valid;
    logic                     busy;
    logic                     overrun;

    modport master (
        output meas_valid, meas_in, setpoint, kp, ki, kd, clr,
        input  u_out, u_valid, busy, overrun
    );

    modport slave (
        input  meas_valid, meas_in, setpoint, kp, ki, kd, clr,
        output u_out, u_valid, busy, overrun
    );

endinterface

// File: rtl/sat_clamp.sv
// Signed saturator: clamps a wide value to +/-LIMIT and narrows it to WIDTH_OUT bits.
module sat_clamp #(
    parameter int WIDTH_IN  = 25,
    parameter int WIDTH_OUT = 24,
    parameter int LIMIT     = 32767
) (
    input  logic signed [WIDTH_IN-1:0]  din,
    output logic signed [WIDTH_OUT-1:0] dout
);

    localparam logic signed [WIDTH_IN-1:0] LIM_HI = WIDTH_IN'(LIMIT);
    localparam logic signed [WIDTH_IN-1:0] LIM_LO = -LIM_HI;

    function automatic logic signed [WIDTH_OUT-1:0] clamp(input logic signed [WIDTH_IN-1:0] x);
        if (x > LIM_HI)
            return LIM_HI[WIDTH_OUT-1:0];
        else if (x < LIM_LO)
            return LIM_LO[WIDTH_OUT-1:0];
        else
            return x[WIDTH_OUT-1:0];
    endfunction

    assign dout = clamp(din);

endmodule

// File: rtl/pid_position_ctrl.sv
// PID position controller: one update per filtered sample, sequenced over seven states
// around a single shared multiplier, with integrator clamp and conditional integration.
module pid_position_ctrl
    import pid_pkg::*;
#(
    parameter int OUT_MAX   = 2047,
    parameter int INT_LIM   = 32767,
    parameter int GAIN_FRAC = Q_FRAC
) (
    input  logic              clk,
    input  logic              rst_n,
    pid_position_ctrl_if.slave bus
);

    pid_state_t state, state_nxt;

    logic        [DATA_W-1:0]      meas_p0, sp_p0;
    logic        [COEF_W-1:0]      kp_p0, ki_p0, kd_p0;
    logic signed [E_W-1:0]         e_p1, e_prev, e_nxt;
    logic signed [D_W-1:0]         d_p1, d_nxt;
    logic signed [I_W-1:0]         integ, integ_clamped;
    logic signed [I_W:0]           integ_sum;
    logic                          first;
    logic signed [1:0]             sat_sgn, e_sgn, out_sgn;
    logic                          integ_hold;
    logic signed [ACC_W-1:0]       acc_p2, acc_shift_p2;
    logic signed [I_W-1:0]         mul_a;
    logic signed [COEF_W:0]        mul_b;
    logic signed [I_W+COEF_W:0]    prod;
    logic signed [DATA_W-1:0]      u_sat, u_out_q;
    logic                          u_valid_q, overrun_q;

    // Error, derivative and integrator candidates, evaluated while in ERR
    assign e_nxt     = $signed({1'b0, sp_p0}) - $signed({1'b0, meas_p0});
    assign d_nxt     = first ? '0 : D_W'(e_nxt) - D_W'(e_prev);
    assign integ_sum = (I_W + 1)'(integ) + (I_W + 1)'(e_nxt);
    assign e_sgn     = (e_nxt > 0) ? 2'sb01 : (e_nxt < 0) ? 2'sb11 : 2'sb00;
    assign integ_hold = (sat_sgn != 2'sb00) && (sat_sgn == e_sgn);
    assign out_sgn   = (acc_shift_p2 > ACC_W'(OUT_MAX))  ? 2'sb01 :
                       (acc_shift_p2 < -ACC_W'(OUT_MAX)) ? 2'sb11 : 2'sb00;

    sat_clamp #(.WIDTH_IN(I_W + 1), .WIDTH_OUT(I_W), .LIMIT(INT_LIM)) u_integ_clamp (
        .din  (integ_sum),
        .dout (integ_clamped)
    );

    sat_clamp #(.WIDTH_IN(ACC_W), .WIDTH_OUT(DATA_W), .LIMIT(OUT_MAX)) u_out_clamp (
        .din  (acc_shift_p2),
        .dout (u_sat)
    );

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            ST_MUL_P: begin mul_a = I_W'(e_p1); mul_b = $signed({1'b0, kp_p0}); end
            ST_MUL_I: begin mul_a = integ;      mul_b = $signed({1'b0, ki_p0}); end
            ST_MUL_D: begin mul_a = I_W'(d_p1); mul_b = $signed({1'b0, kd_p0}); end
            default:  ;
        endcase
    end

    assign prod = mul_a * mul_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.clr) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (bus.meas_valid) state_nxt = ST_ERR;
                ST_ERR:   state_nxt = ST_MUL_P;
                ST_MUL_P: state_nxt = ST_MUL_I;
                ST_MUL_I: state_nxt = ST_MUL_D;
                ST_MUL_D: state_nxt = ST_SUM;
                ST_SUM:   state_nxt = ST_SAT;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy    = (state != ST_IDLE);
        bus.u_out   = u_out_q;
        bus.u_valid = u_valid_q;
        bus.overrun = overrun_q;
    end

    // Controller state: loop memory, output register and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u_out_q   <= '0;
            u_valid_q <= 1'b0;
            overrun_q <= 1'b0;
            integ     <= '0;
            e_prev    <= '0;
            sat_sgn   <= 2'sb00;
            first     <= 1'b1;
        end else begin
            u_valid_q <= 1'b0;
            if (bus.meas_valid && !bus.clr && state != ST_IDLE)
                overrun_q <= 1'b1;
            if (bus.clr) begin
                integ   <= '0;
                e_prev  <= '0;
                sat_sgn <= 2'sb00;
                first   <= 1'b1;
            end else begin
                case (state)
                    ST_ERR: begin
                        if (!integ_hold)
                            integ <= integ_clamped;
                        e_prev <= e_nxt;
                        first  <= 1'b0;
                    end
                    ST_SAT: begin
                        u_out_q   <= u_sat;
                        sat_sgn   <= out_sgn;
                        u_valid_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Datapath: capture (p0), error terms (p1), accumulate and scale (p2)
    always_ff @(posedge clk) begin
        case (state)
            ST_IDLE: begin
                if (bus.meas_valid && !bus.clr) begin
                    meas_p0 <= bus.meas_in;
                    sp_p0   <= bus.setpoint;
                    kp_p0   <= bus.kp;
                    ki_p0   <= bus.ki;
                    kd_p0   <= bus.kd;
                end
            end
            ST_ERR: begin
                e_p1   <= e_nxt;
                d_p1   <= d_nxt;
                acc_p2 <= '0;
            end
            ST_MUL_P, ST_MUL_I, ST_MUL_D: acc_p2 <= acc_p2 + ACC_W'(prod);
            ST_SUM:  acc_shift_p2 <= acc_p2 >>> GAIN_FRAC;
            default: ;
        endcase
    end

endmodule
